// File: rtl/vga_display_ctrl.sv
// VGA display controller: pixel prescaler, h/v timing counters, sync generation,
// four-mode pattern generator and frame bookkeeping. Every output is registered.
module vga_display_ctrl #(
    parameter int   H_DISPLAY = 640,
    parameter int   H_FP      = 16,
    parameter int   H_SYNC    = 96,
    parameter int   H_BP      = 48,
    parameter int   V_DISPLAY = 480,
    parameter int   V_FP      = 10,
    parameter int   V_SYNC    = 2,
    parameter int   V_BP      = 33,
    parameter int   CLK_DIV   = 4,
    parameter logic SYNC_POL  = 1'b0,
    parameter int   RGB_W     = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic [RGB_W-1:0] sw_rgb,
    output logic             hsync,
    output logic             vsync,
    output logic             video_on,
    output logic [9:0]       pixel_x,
    output logic [9:0]       pixel_y,
    output logic [RGB_W-1:0] rgb,
    output logic             pixel_tick,
    output logic             frame_start,
    output logic [7:0]       frame_count
);
    localparam int H_TOTAL = H_DISPLAY + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_DISPLAY + V_FP + V_SYNC + V_BP;
    localparam int C       = RGB_W / 3;
    localparam int PW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [PW-1:0] P_LAST   = PW'(CLK_DIV - 1);
    localparam logic [9:0]    H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]    V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0]    H_VIS    = 10'(H_DISPLAY);
    localparam logic [9:0]    V_VIS    = 10'(V_DISPLAY);
    localparam logic [9:0]    HS_BEG   = 10'(H_DISPLAY + H_FP);
    localparam logic [9:0]    HS_END   = 10'(H_DISPLAY + H_FP + H_SYNC - 1);
    localparam logic [9:0]    VS_BEG   = 10'(V_DISPLAY + V_FP);
    localparam logic [9:0]    VS_END   = 10'(V_DISPLAY + V_FP + V_SYNC - 1);
    localparam logic [9:0]    BAR_LAST = 10'(H_DISPLAY / 8 - 1);

    typedef enum logic [1:0] {
        PAT_SOLID    = 2'd0,
        PAT_BARS     = 2'd1,
        PAT_CHECKER  = 2'd2,
        PAT_GRADIENT = 2'd3
    } pattern_e;

    logic [PW-1:0]    presc_q, presc_d;
    logic [9:0]       h_q, h_d, v_q, v_d;
    pattern_e         mode_q, mode_d;
    logic [9:0]       bar_cnt_q, bar_cnt_d;
    logic [2:0]       bar_idx_q, bar_idx_d;

    logic             hsync_q, hsync_d, vsync_q, vsync_d;
    logic             video_on_q, video_on_d;
    logic [9:0]       pixel_x_q, pixel_x_d, pixel_y_q, pixel_y_d;
    logic [RGB_W-1:0] rgb_q, rgb_d;
    logic             pixel_tick_q, pixel_tick_d;
    logic             frame_start_q, frame_start_d;
    logic [7:0]       frame_count_q, frame_count_d;

    logic             tick, h_wrap, v_wrap;
    logic             bar_r, bar_g, bar_b;
    logic [RGB_W-1:0] pattern;

    always_comb begin
        tick      = (presc_q == P_LAST);
        h_wrap    = tick && (h_q == H_LAST);
        v_wrap    = h_wrap && (v_q == V_LAST);

        presc_d   = tick ? '0 : presc_q + PW'(1);
        h_d       = h_q;
        v_d       = v_q;
        mode_d    = mode_q;
        bar_cnt_d = bar_cnt_q;
        bar_idx_d = bar_idx_q;

        if (tick) begin
            h_d = h_wrap ? '0 : h_q + 10'd1;
            if (h_wrap) begin
                v_d = v_wrap ? '0 : v_q + 10'd1;
            end
            if (v_wrap) begin
                mode_d = pattern_e'(mode);
            end
            // Bar index comes from a width counter restarted every line, avoiding a divider
            if (h_wrap) begin
                bar_cnt_d = '0;
                bar_idx_d = '0;
            end else if (bar_cnt_q == BAR_LAST) begin
                bar_cnt_d = '0;
                bar_idx_d = bar_idx_q + 3'd1;
            end else begin
                bar_cnt_d = bar_cnt_q + 10'd1;
            end
        end

        // White, yellow, cyan, green, magenta, red, blue, black
        bar_r = ~bar_idx_d[1];
        bar_g = ~bar_idx_d[2];
        bar_b = ~bar_idx_d[0];

        pattern = sw_rgb;
        case (mode_d)
            PAT_SOLID:    pattern = sw_rgb;
            PAT_BARS:     pattern = {{C{bar_r}}, {C{bar_g}}, {C{bar_b}}};
            PAT_CHECKER:  pattern = (h_d[5] ^ v_d[5]) ? ~sw_rgb : sw_rgb;
            PAT_GRADIENT: pattern = {3{h_d[9 -: C]}};
            default:      pattern = sw_rgb;
        endcase

        // Output stage is fed from next-state counters so all outputs move together
        // with pixel_tick on the advancing edge.
        video_on_d    = (h_d < H_VIS) && (v_d < V_VIS);
        pixel_x_d     = h_d;
        pixel_y_d     = v_d;
        rgb_d         = video_on_d ? pattern : '0;
        hsync_d       = ((h_d >= HS_BEG) && (h_d <= HS_END)) ? SYNC_POL : ~SYNC_POL;
        vsync_d       = ((v_d >= VS_BEG) && (v_d <= VS_END)) ? SYNC_POL : ~SYNC_POL;
        pixel_tick_d  = tick;
        frame_start_d = v_wrap;
        frame_count_d = v_wrap ? frame_count_q + 8'd1 : frame_count_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q       <= '0;
            h_q           <= '0;
            v_q           <= '0;
            mode_q        <= PAT_SOLID;
            bar_cnt_q     <= '0;
            bar_idx_q     <= '0;
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            video_on_q    <= 1'b0;
            pixel_x_q     <= '0;
            pixel_y_q     <= '0;
            rgb_q         <= '0;
            pixel_tick_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_count_q <= '0;
        end else begin
            presc_q       <= presc_d;
            h_q           <= h_d;
            v_q           <= v_d;
            mode_q        <= mode_d;
            bar_cnt_q     <= bar_cnt_d;
            bar_idx_q     <= bar_idx_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            video_on_q    <= video_on_d;
            pixel_x_q     <= pixel_x_d;
            pixel_y_q     <= pixel_y_d;
            rgb_q         <= rgb_d;
            pixel_tick_q  <= pixel_tick_d;
            frame_start_q <= frame_start_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign video_on    = video_on_q;
    assign pixel_x     = pixel_x_q;
    assign pixel_y     = pixel_y_q;
    assign rgb         = rgb_q;
    assign pixel_tick  = pixel_tick_q;
    assign frame_start = frame_start_q;
    assign frame_count = frame_count_q;
endmodule

// File: tb/tb_vga_display_ctrl.sv
// Directed bench: default 640x480 instance for line timing, a reduced-size instance
// for framing and patterns, and a CLK_DIV=1 active-high-sync instance.
module tb_vga_display_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    logic [11:0] sw_rgb = 12'hA5C;

    // default instance
    logic rst0 = 1'b1;
    logic [1:0] mode0 = 2'd0;
    logic hsync0, vsync0, video_on0, pixel_tick0, frame_start0;
    logic [9:0] px0, py0;
    logic [11:0] rgb0;
    logic [7:0] fc0;

    // reduced instance: 256x8 visible, H_TOTAL 272, V_TOTAL 12, CLK_DIV 1
    logic rst1 = 1'b1;
    logic [1:0] mode1 = 2'd0;
    logic hsync1, vsync1, video_on1, pixel_tick1, frame_start1;
    logic [9:0] px1, py1;
    logic [11:0] rgb1;
    logic [7:0] fc1;

    // tiny instance: 8x4 visible, H_TOTAL 12, V_TOTAL 7, CLK_DIV 1, active-high syncs
    logic rst2 = 1'b1;
    logic [1:0] mode2 = 2'd0;
    logic hsync2, vsync2, video_on2, pixel_tick2, frame_start2;
    logic [9:0] px2, py2;
    logic [11:0] rgb2;
    logic [7:0] fc2;

    vga_display_ctrl dut0 (
        .clk(clk), .rst(rst0), .mode(mode0), .sw_rgb(sw_rgb),
        .hsync(hsync0), .vsync(vsync0), .video_on(video_on0),
        .pixel_x(px0), .pixel_y(py0), .rgb(rgb0),
        .pixel_tick(pixel_tick0), .frame_start(frame_start0), .frame_count(fc0)
    );

    vga_display_ctrl #(
        .H_DISPLAY(256), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_DISPLAY(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .CLK_DIV(1), .SYNC_POL(1'b0), .RGB_W(12)
    ) dut1 (
        .clk(clk), .rst(rst1), .mode(mode1), .sw_rgb(sw_rgb),
        .hsync(hsync1), .vsync(vsync1), .video_on(video_on1),
        .pixel_x(px1), .pixel_y(py1), .rgb(rgb1),
        .pixel_tick(pixel_tick1), .frame_start(frame_start1), .frame_count(fc1)
    );

    vga_display_ctrl #(
        .H_DISPLAY(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_DISPLAY(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .CLK_DIV(1), .SYNC_POL(1'b1), .RGB_W(12)
    ) dut2 (
        .clk(clk), .rst(rst2), .mode(mode2), .sw_rgb(sw_rgb),
        .hsync(hsync2), .vsync(vsync2), .video_on(video_on2),
        .pixel_x(px2), .pixel_y(py2), .rgb(rgb2),
        .pixel_tick(pixel_tick2), .frame_start(frame_start2), .frame_count(fc2)
    );

    // ---------------- default-instance model ----------------
    int x0, y0, pc0;
    bit ticked0;
    int err0_pos, err0_tick, err0_hs, err0_vs, err0_vid, err0_rgb;
    int hs_low, hs_first, hs_last, vid_fall;

    task automatic reset_model0();
        x0 = 0; y0 = 0; pc0 = 0; ticked0 = 0;
        err0_pos = 0; err0_tick = 0; err0_hs = 0; err0_vs = 0; err0_vid = 0; err0_rgb = 0;
    endtask

    task automatic tick0();
        bit vis;
        @(negedge clk);
        pc0 = (pc0 == 3) ? 0 : pc0 + 1;
        ticked0 = (pc0 == 0);
        if (ticked0) begin
            if (x0 == 799) begin
                x0 = 0;
                y0 = (y0 == 524) ? 0 : y0 + 1;
            end else begin
                x0++;
            end
        end
        vis = (x0 < 640) && (y0 < 480);
        if (px0 !== 10'(x0) || py0 !== 10'(y0)) err0_pos++;
        if (pixel_tick0 !== ticked0) err0_tick++;
        if (hsync0 !== !(x0 >= 656 && x0 <= 751)) err0_hs++;
        if (vsync0 !== !(y0 >= 490 && y0 <= 491)) err0_vs++;
        if (video_on0 !== vis) err0_vid++;
        if (rgb0 !== (vis ? 12'hA5C : 12'h000)) err0_rgb++;
        if (ticked0 && y0 == 1 && hsync0 === 1'b0) begin
            hs_low++;
            if (hs_first < 0) hs_first = x0;
            hs_last = x0;
        end
        if (ticked0 && y0 == 1 && video_on0 === 1'b0 && vid_fall < 0) vid_fall = x0;
    endtask

    // ---------------- reduced-instance model ----------------
    int x1, y1, mm1, c1;
    bit wrapped1;
    int err1_pos, err1_tick, err1_hs, err1_vs, err1_fs, err1_vid, err1_solid, err1_sp;
    int nfs1, first_fs1, last_fs1;

    task automatic tick1();
        bit vis1;
        @(negedge clk);
        c1++;
        wrapped1 = 0;
        if (x1 == 271) begin
            x1 = 0;
            if (y1 == 11) begin
                y1 = 0;
                wrapped1 = 1;
                mm1 = int'(mode1);
            end else begin
                y1++;
            end
        end else begin
            x1++;
        end
        vis1 = (x1 < 256) && (y1 < 8);
        if (px1 !== 10'(x1) || py1 !== 10'(y1)) err1_pos++;
        if (pixel_tick1 !== 1'b1) err1_tick++;
        if (hsync1 !== !(x1 >= 260 && x1 <= 267)) err1_hs++;
        if (vsync1 !== !(y1 >= 9 && y1 <= 10)) err1_vs++;
        if (frame_start1 !== wrapped1) err1_fs++;
        if (video_on1 !== vis1) err1_vid++;
        if (mm1 == 0 && rgb1 !== (vis1 ? 12'hA5C : 12'h000)) err1_solid++;
        if (wrapped1) begin
            nfs1++;
            if (first_fs1 < 0) first_fs1 = c1;
            else if (c1 - last_fs1 != 3264) err1_sp++;
            last_fs1 = c1;
        end
    endtask

    task automatic goto1(input int tx, input int ty);
        int guard = 0;
        while (!(x1 == tx && y1 == ty) && guard < 4000) begin
            tick1();
            guard++;
        end
        if (guard >= 4000) begin
            n_total++;
            $display("FAIL goto1_timeout: reached (%0d,%0d), wanted (%0d,%0d)", x1, y1, tx, ty);
        end
    endtask

    // ---------------- tiny-instance model ----------------
    int x2, y2, c2;

    task automatic tick2();
        @(negedge clk);
        c2++;
        if (x2 == 11) begin
            x2 = 0;
            y2 = (y2 == 6) ? 0 : y2 + 1;
        end else begin
            x2++;
        end
    endtask

    task automatic goto2(input int tx, input int ty);
        int guard = 0;
        while (!(x2 == tx && y2 == ty) && guard < 200) begin
            tick2();
            guard++;
        end
        if (guard >= 200) begin
            n_total++;
            $display("FAIL goto2_timeout: reached (%0d,%0d), wanted (%0d,%0d)", x2, y2, tx, ty);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
        repeat (3) @(negedge clk);
        n_total++; if (px0 !== 10'd0 || py0 !== 10'd0) $display("FAIL rst_xy: got (%0d,%0d) want (0,0)", px0, py0); else n_pass++;
        n_total++; if (rgb0 !== 12'h000) $display("FAIL rst_rgb: got %h want 000", rgb0); else n_pass++;
        n_total++; if (video_on0 !== 1'b0) $display("FAIL rst_video_on: got %b want 0", video_on0); else n_pass++;
        n_total++; if ({hsync0, vsync0} !== 2'b11) $display("FAIL rst_sync: got %b want 11", {hsync0, vsync0}); else n_pass++;
        n_total++; if ({pixel_tick0, frame_start0} !== 2'b00) $display("FAIL rst_pulses: got %b want 00", {pixel_tick0, frame_start0}); else n_pass++;
        n_total++; if (fc0 !== 8'd0) $display("FAIL rst_frame_count: got %0d want 0", fc0); else n_pass++;
    endtask

    task automatic test_reset_release();
        rst0 = 1'b0;
        reset_model0();
        tick0(); tick0(); tick0();
        n_total++; if (px0 !== 10'd0 || pixel_tick0 !== 1'b0) $display("FAIL rel_clk3: got x=%0d tick=%b want x=0 tick=0", px0, pixel_tick0); else n_pass++;
        tick0();
        n_total++; if (px0 !== 10'd1 || pixel_tick0 !== 1'b1) $display("FAIL rel_clk4: got x=%0d tick=%b want x=1 tick=1", px0, pixel_tick0); else n_pass++;
        tick0();
        n_total++; if (pixel_tick0 !== 1'b0) $display("FAIL rel_clk5_tick: got %b want 0", pixel_tick0); else n_pass++;
        tick0(); tick0(); tick0();
        n_total++; if (px0 !== 10'd2 || pixel_tick0 !== 1'b1) $display("FAIL rel_clk8: got x=%0d tick=%b want x=2 tick=1", px0, pixel_tick0); else n_pass++;
    endtask

    task automatic test_hsync();
        int guard;
        time t1, t2;
        hs_low = 0; hs_first = -1; hs_last = -1; vid_fall = -1;
        guard = 0;
        while (!(ticked0 && x0 == 0 && y0 == 1) && guard < 4000) begin tick0(); guard++; end
        t1 = $time;
        tick0();
        while (!(ticked0 && x0 == 0 && y0 == 2) && guard < 8000) begin tick0(); guard++; end
        t2 = $time;
        n_total++; if (guard >= 8000) $display("FAIL hs_timeout: waited %0d clk", guard); else n_pass++;
        n_total++; if (t2 - t1 != 32000) $display("FAIL line_period: got %0t want 32000", t2 - t1); else n_pass++;
        n_total++; if (hs_low != 96) $display("FAIL hsync_width: got %0d want 96", hs_low); else n_pass++;
        n_total++; if (hs_first != 656 || hs_last != 751) $display("FAIL hsync_window: got %0d..%0d want 656..751", hs_first, hs_last); else n_pass++;
        n_total++; if (vid_fall != 640) $display("FAIL video_on_fall: got %0d want 640", vid_fall); else n_pass++;
        n_total++; if (err0_pos != 0 || err0_tick != 0) $display("FAIL d0_counters: got pos_err=%0d tick_err=%0d want 0", err0_pos, err0_tick); else n_pass++;
        n_total++; if (err0_hs != 0 || err0_vs != 0 || err0_vid != 0) $display("FAIL d0_align: got hs=%0d vs=%0d vid=%0d want 0", err0_hs, err0_vs, err0_vid); else n_pass++;
        n_total++; if (err0_rgb != 0) $display("FAIL d0_solid_rgb: got %0d errors want 0", err0_rgb); else n_pass++;
    endtask

    task automatic test_async_reset();
        int guard = 0;
        while (!(ticked0 && x0 == 300) && guard < 2000) begin tick0(); guard++; end
        n_total++; if (px0 !== 10'd300 || py0 !== 10'd2) $display("FAIL ar_pre: got (%0d,%0d) want (300,2)", px0, py0); else n_pass++;
        #2;
        rst0 = 1'b1;
        #1;
        n_total++; if (px0 !== 10'd0 || py0 !== 10'd0) $display("FAIL ar_xy: got (%0d,%0d) want (0,0)", px0, py0); else n_pass++;
        n_total++; if (rgb0 !== 12'h000 || video_on0 !== 1'b0) $display("FAIL ar_video: got rgb=%h von=%b want 000/0", rgb0, video_on0); else n_pass++;
        n_total++; if ({hsync0, vsync0, pixel_tick0} !== 3'b110) $display("FAIL ar_sync: got %b want 110", {hsync0, vsync0, pixel_tick0}); else n_pass++;
        @(negedge clk);
        rst0 = 1'b0;
        reset_model0();
        repeat (4) tick0();
        n_total++; if (px0 !== 10'd1 || py0 !== 10'd0 || pixel_tick0 !== 1'b1) $display("FAIL ar_restart: got (%0d,%0d) tick=%b want (1,0) 1", px0, py0, pixel_tick0); else n_pass++;
    endtask

    task automatic test_vsync_framing();
        rst1 = 1'b0;
        x1 = 0; y1 = 0; mm1 = 0; c1 = 0;
        err1_pos = 0; err1_tick = 0; err1_hs = 0; err1_vs = 0; err1_fs = 0; err1_vid = 0; err1_solid = 0; err1_sp = 0;
        nfs1 = 0; first_fs1 = -1; last_fs1 = -1;
        repeat (2 * 3264) tick1();
        n_total++; if (err1_pos != 0 || err1_tick != 0) $display("FAIL d1_counters: got pos_err=%0d tick_err=%0d want 0", err1_pos, err1_tick); else n_pass++;
        n_total++; if (err1_hs != 0 || err1_vs != 0 || err1_vid != 0) $display("FAIL d1_sync: got hs=%0d vs=%0d vid=%0d want 0", err1_hs, err1_vs, err1_vid); else n_pass++;
        n_total++; if (err1_fs != 0) $display("FAIL frame_start_pulses: got %0d errors want 0", err1_fs); else n_pass++;
        n_total++; if (nfs1 != 2 || first_fs1 != 3264 || err1_sp != 0) $display("FAIL frame_spacing: got n=%0d first=%0d sp_err=%0d want 2/3264/0", nfs1, first_fs1, err1_sp); else n_pass++;
        n_total++; if (fc1 !== 8'd2 || frame_start1 !== 1'b1 || px1 !== 10'd0 || py1 !== 10'd0) $display("FAIL frame_count_2: got fc=%0d fs=%b (%0d,%0d) want 2 1 (0,0)", fc1, frame_start1, px1, py1); else n_pass++;
        n_total++; if (err1_solid != 0) $display("FAIL mode0_solid: got %0d errors want 0", err1_solid); else n_pass++;
    endtask

    task automatic test_mode_change();
        err1_solid = 0;
        goto1(0, 5);
        mode1 = 2'd1;
        tick1();
        goto1(0, 0);
        n_total++; if (err1_solid != 0) $display("FAIL no_tearing: got %0d errors want 0", err1_solid); else n_pass++;
        n_total++; if (rgb1 !== 12'hFFF) $display("FAIL bars_first_pixel: got %h want FFF", rgb1); else n_pass++;
        goto1(31, 0);
        n_total++; if (rgb1 !== 12'hFFF) $display("FAIL bars_x31: got %h want FFF", rgb1); else n_pass++;
        tick1();
        n_total++; if (rgb1 !== 12'hFF0) $display("FAIL bars_x32: got %h want FF0", rgb1); else n_pass++;
        goto1(64, 0);
        n_total++; if (rgb1 !== 12'h0FF) $display("FAIL bars_x64: got %h want 0FF", rgb1); else n_pass++;
        goto1(160, 0);
        n_total++; if (rgb1 !== 12'hF00) $display("FAIL bars_x160: got %h want F00", rgb1); else n_pass++;
        goto1(255, 0);
        n_total++; if (rgb1 !== 12'h000) $display("FAIL bars_x255: got %h want 000", rgb1); else n_pass++;
        goto1(224, 1);
        n_total++; if (rgb1 !== 12'h000) $display("FAIL bars_x224: got %h want 000", rgb1); else n_pass++;
        tick1();
        goto1(200, 9);
        n_total++; if (rgb1 !== 12'h000) $display("FAIL bars_blank: got %h want 000", rgb1); else n_pass++;
    endtask

    task automatic test_patterns();
        mode1 = 2'd2;
        tick1();
        goto1(0, 0);
        n_total++; if (rgb1 !== 12'hA5C) $display("FAIL checker_0_0: got %h want A5C", rgb1); else n_pass++;
        goto1(32, 0);
        n_total++; if (rgb1 !== 12'h5A3) $display("FAIL checker_32_0: got %h want 5A3", rgb1); else n_pass++;
        goto1(64, 0);
        n_total++; if (rgb1 !== 12'hA5C) $display("FAIL checker_64_0: got %h want A5C", rgb1); else n_pass++;
        goto1(0, 3);
        mode1 = 2'd3;
        tick1();
        goto1(0, 0);
        n_total++; if (rgb1 !== 12'h000) $display("FAIL gradient_x0: got %h want 000", rgb1); else n_pass++;
        goto1(64, 0);
        n_total++; if (rgb1 !== 12'h111) $display("FAIL gradient_x64: got %h want 111", rgb1); else n_pass++;
        goto1(200, 0);
        n_total++; if (rgb1 !== 12'h333) $display("FAIL gradient_x200: got %h want 333", rgb1); else n_pass++;
    endtask

    task automatic test_clkdiv1_syncpol();
        n_total++; if ({hsync2, vsync2, video_on2} !== 3'b000 || rgb2 !== 12'h000) $display("FAIL d2_reset: got sync=%b von=%b rgb=%h want 00 0 000", {hsync2, vsync2}, video_on2, rgb2); else n_pass++;
        rst2 = 1'b0;
        x2 = 0; y2 = 0; c2 = 0;
        tick2();
        n_total++; if (px2 !== 10'd1 || pixel_tick2 !== 1'b1) $display("FAIL d2_first: got x=%0d tick=%b want 1 1", px2, pixel_tick2); else n_pass++;
        tick2();
        n_total++; if (px2 !== 10'd2 || pixel_tick2 !== 1'b1) $display("FAIL d2_second: got x=%0d tick=%b want 2 1", px2, pixel_tick2); else n_pass++;
        goto2(8, 0);
        n_total++; if (hsync2 !== 1'b0) $display("FAIL d2_hs_x8: got %b want 0", hsync2); else n_pass++;
        tick2();
        n_total++; if (hsync2 !== 1'b1) $display("FAIL d2_hs_x9: got %b want 1", hsync2); else n_pass++;
        goto2(11, 0);
        n_total++; if (hsync2 !== 1'b0) $display("FAIL d2_hs_x11: got %b want 0", hsync2); else n_pass++;
        goto2(0, 5);
        n_total++; if (vsync2 !== 1'b1 || py2 !== 10'd5) $display("FAIL d2_vs_y5: got vs=%b y=%0d want 1 5", vsync2, py2); else n_pass++;
        goto2(0, 6);
        n_total++; if (vsync2 !== 1'b0) $display("FAIL d2_vs_y6: got %b want 0", vsync2); else n_pass++;
    endtask

    task automatic test_frame_count_wrap();
        while (c2 < 255 * 84) tick2();
        n_total++; if (fc2 !== 8'd255 || frame_start2 !== 1'b1) $display("FAIL fc_255: got fc=%0d fs=%b want 255 1", fc2, frame_start2); else n_pass++;
        while (c2 < 256 * 84) tick2();
        n_total++; if (fc2 !== 8'd0 || frame_start2 !== 1'b1) $display("FAIL fc_wrap: got fc=%0d fs=%b want 0 1", fc2, frame_start2); else n_pass++;
        tick2();
        n_total++; if (frame_start2 !== 1'b0 || fc2 !== 8'd0) $display("FAIL fs_one_clk: got fs=%b fc=%0d want 0 0", frame_start2, fc2); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_reset_release();
        test_hsync();
        test_async_reset();
        test_vsync_framing();
        test_mode_change();
        test_patterns();
        test_clkdiv1_syncpol();
        test_frame_count_wrap();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
